midi_avl_sched: RTL and testbench

MIDI_AVL_SCHED -- requirements
Module: midi_avl_sched

---
 rtl/midi_avl_sched.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_midi_avl_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_avl_sched.sv
// midi_avl_sched: merges MIDI messages from two sources (USB MIDI and the
// on-board test sequencer) into single Avalon writes for the synth slave.
// Each source has a small message FIFO; a round-robin arbiter feeds a
// four-state FSM that decodes note on/off, control changes and the
// all-notes-off sweep. Undecodable messages are counted in DROP_CNT.

// Per-source message FIFO; push and pop may happen in the same cycle.
module midi_avl_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        push,
  input  logic        pop,
  input  logic [23:0] din,
  output logic [23:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = (AW)'(0);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  logic [23:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (cnt_r == FULL_CNT);
  assign empty     = (cnt_r == ZERO_CNT);
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A full FIFO can still take a message when one leaves in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= ZERO_CNT;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// Scheduler top: two FIFOs, round-robin grant, decode FSM, Avalon master.
module midi_avl_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIDI_CH    = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        A_VALID,
  input  logic [23:0] A_MSG,
  output logic        A_READY,
  input  logic        B_VALID,
  input  logic [23:0] B_MSG,
  output logic        B_READY,
  output logic        AVL_WRITE,
  output logic [7:0]  AVL_ADDR,
  output logic [31:0] AVL_WRITEDATA,
  output logic        SWEEP_ACTIVE,
  output logic [7:0]  DROP_CNT
);

  localparam logic [3:0] CH = 4'(MIDI_CH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_SWEEP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DEC_DROP  = 2'd0,
    DEC_WRITE = 2'd1,
    DEC_SWEEP = 2'd2
  } dec_t;

  state_t      state_r;
  logic [23:0] msg_r;
  logic        last_grant_r;   // 1'b0 = A granted last, 1'b1 = B
  logic [6:0]  sweep_cnt_r;
  logic        avl_write_r;
  logic [7:0]  avl_addr_r;
  logic [31:0] avl_data_r;
  logic        sweep_active_r;
  logic [7:0]  drop_cnt_r;

  logic [23:0] a_dout_s;
  logic [23:0] b_dout_s;
  logic        a_full_s;
  logic        b_full_s;
  logic        a_empty_s;
  logic        b_empty_s;
  logic        grant_a_s;
  logic        grant_b_s;

  dec_t        dec_kind_s;
  logic [7:0]  dec_addr_s;
  logic [31:0] dec_data_s;
  logic [7:0]  status_s;
  logic [7:0]  data1_s;
  logic [7:0]  data2_s;

  assign A_READY = !a_full_s;
  assign B_READY = !b_full_s;

  midi_avl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (A_VALID && !a_full_s),
    .pop   (grant_a_s),
    .din   (A_MSG),
    .dout  (a_dout_s),
    .full  (a_full_s),
    .empty (a_empty_s)
  );

  midi_avl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (B_VALID && !b_full_s),
    .pop   (grant_b_s),
    .din   (B_MSG),
    .dout  (b_dout_s),
    .full  (b_full_s),
    .empty (b_empty_s)
  );

  // Round-robin grant: only from IDLE with ENABLE high; alternate when both wait.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if ((state_r == ST_IDLE) && ENABLE) begin
      if (!a_empty_s && !b_empty_s) begin
        if (last_grant_r) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (!a_empty_s) begin
        grant_a_s = 1'b1;
      end else if (!b_empty_s) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign status_s = msg_r[23:16];
  assign data1_s  = msg_r[15:8];
  assign data2_s  = msg_r[7:0];

  // Classify the held message and form its Avalon address and data.
  always_comb begin
    dec_kind_s = DEC_DROP;
    dec_addr_s = 8'h00;
    dec_data_s = 32'h0000_0000;
    if ((status_s[3:0] != CH) || data1_s[7] || data2_s[7]) begin
      dec_kind_s = DEC_DROP;
    end else begin
      case (status_s[7:4])
        4'h9: begin
          // Note-on with zero velocity is a note-off; bit 7 carries on/off.
          dec_kind_s = DEC_WRITE;
          dec_addr_s = {1'b0, data1_s[6:0]};
          dec_data_s = {24'h00_0000, (data2_s != 8'h00), data2_s[6:0]};
        end
        4'h8: begin
          dec_kind_s = DEC_WRITE;
          dec_addr_s = {1'b0, data1_s[6:0]};
          dec_data_s = {24'h00_0000, 1'b0, data2_s[6:0]};
        end
        4'hB: begin
          if ((data1_s >= 8'd16) && (data1_s <= 8'd21)) begin
            // CC 16..21 are 0x10..0x15, so the low three bits are the index.
            dec_kind_s = DEC_WRITE;
            dec_addr_s = {5'b10000, data1_s[2:0]};
            dec_data_s = {12'h000, data2_s[6:0], 13'h0000};
          end else if (data1_s == 8'd64) begin
            dec_kind_s = DEC_WRITE;
            dec_addr_s = 8'h86;
            dec_data_s = {25'h000_0000, data2_s[6:0]};
          end else if (data1_s == 8'd123) begin
            dec_kind_s = DEC_SWEEP;
          end else begin
            dec_kind_s = DEC_DROP;
          end
        end
        default: dec_kind_s = DEC_DROP;
      endcase
    end
  end

  // Scheduler FSM with registered Avalon outputs, drop counter and sweep counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r        <= ST_IDLE;
      msg_r          <= 24'h00_0000;
      last_grant_r   <= 1'b0;
      sweep_cnt_r    <= 7'd0;
      avl_write_r    <= 1'b0;
      avl_addr_r     <= 8'h00;
      avl_data_r     <= 32'h0000_0000;
      sweep_active_r <= 1'b0;
      drop_cnt_r     <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          avl_write_r <= 1'b0;
          if (grant_a_s) begin
            msg_r        <= a_dout_s;
            last_grant_r <= 1'b0;
            state_r      <= ST_DECODE;
          end else if (grant_b_s) begin
            msg_r        <= b_dout_s;
            last_grant_r <= 1'b1;
            state_r      <= ST_DECODE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DECODE: begin
          case (dec_kind_s)
            DEC_WRITE: begin
              avl_write_r <= 1'b1;
              avl_addr_r  <= dec_addr_s;
              avl_data_r  <= dec_data_s;
              state_r     <= ST_WRITE;
            end
            DEC_SWEEP: begin
              // First sweep write (key 0) is presented in the first SWEEP cycle.
              avl_write_r    <= 1'b1;
              avl_addr_r     <= 8'h00;
              avl_data_r     <= 32'h0000_0000;
              sweep_active_r <= 1'b1;
              sweep_cnt_r    <= 7'd0;
              state_r        <= ST_SWEEP;
            end
            default: begin
              if (drop_cnt_r != 8'hFF) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
              end else begin
                drop_cnt_r <= drop_cnt_r;
              end
              state_r <= ST_IDLE;
            end
          endcase
        end
        ST_WRITE: begin
          avl_write_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        ST_SWEEP: begin
          if (sweep_cnt_r == 7'd127) begin
            avl_write_r    <= 1'b0;
            sweep_active_r <= 1'b0;
            sweep_cnt_r    <= 7'd0;
            state_r        <= ST_IDLE;
          end else begin
            avl_write_r <= 1'b1;
            avl_addr_r  <= {1'b0, sweep_cnt_r + 7'd1};
            sweep_cnt_r <= sweep_cnt_r + 7'd1;
            state_r     <= ST_SWEEP;
          end
        end
        default: begin
          avl_write_r    <= 1'b0;
          sweep_active_r <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

  assign AVL_WRITE     = avl_write_r;
  assign AVL_ADDR      = avl_addr_r;
  assign AVL_WRITEDATA = avl_data_r;
  assign SWEEP_ACTIVE  = sweep_active_r;
  assign DROP_CNT      = drop_cnt_r;

endmodule

// File: tb/tb_midi_avl_sched.sv
// Directed testbench for midi_avl_sched (FIFO_DEPTH=4, MIDI_CH=0).
// A negedge monitor logs every Avalon write; the directed steps compare
// the log and the live outputs against hand-computed values.
module tb_midi_avl_sched;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        A_VALID;
  logic [23:0] A_MSG;
  logic        A_READY;
  logic        B_VALID;
  logic [23:0] B_MSG;
  logic        B_READY;
  logic        AVL_WRITE;
  logic [7:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic        SWEEP_ACTIVE;
  logic [7:0]  DROP_CNT;

  midi_avl_sched #(.FIFO_DEPTH(4), .MIDI_CH(0)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ENABLE        (ENABLE),
    .A_VALID       (A_VALID),
    .A_MSG         (A_MSG),
    .A_READY       (A_READY),
    .B_VALID       (B_VALID),
    .B_MSG         (B_MSG),
    .B_READY       (B_READY),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .SWEEP_ACTIVE  (SWEEP_ACTIVE),
    .DROP_CNT      (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_n     = 0;
  int base;
  int pcyc;

  logic [7:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  logic        wr_sw   [0:1023];
  int          wr_cyc  [0:1023];
  logic [7:0]  ord     [0:5];

  // Cycle counter used for latency measurement.
  always @(posedge CLK) cyc <= cyc + 1;

  // Log every Avalon write, sampled away from the active edge.
  always @(negedge CLK) begin
    if (AVL_WRITE === 1'b1 && wr_n < 1024) begin
      wr_addr[wr_n] = AVL_ADDR;
      wr_data[wr_n] = AVL_WRITEDATA;
      wr_sw[wr_n]   = SWEEP_ACTIVE;
      wr_cyc[wr_n]  = cyc;
      wr_n          = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_a(input logic [23:0] m);
    int g = 0;
    while (A_READY !== 1'b1 && g < 200) begin
      tick(1);
      g++;
    end
    if (g >= 200) check("push_a_timeout", 32'(A_READY), 32'd1);
    A_VALID = 1'b1;
    A_MSG   = m;
    tick(1);
    A_VALID = 1'b0;
  endtask

  task automatic push_b(input logic [23:0] m);
    int g = 0;
    while (B_READY !== 1'b1 && g < 200) begin
      tick(1);
      g++;
    end
    if (g >= 200) check("push_b_timeout", 32'(B_READY), 32'd1);
    B_VALID = 1'b1;
    B_MSG   = m;
    tick(1);
    B_VALID = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    int g = 0;
    while (wr_n < target && g < budget) begin
      tick(1);
      g++;
    end
    check($sformatf("wait_writes_%0d", target), 32'(wr_n >= target), 32'd1);
  endtask

  initial begin
    RESET   = 1'b1;
    ENABLE  = 1'b1;
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    A_MSG   = 24'h0;
    B_MSG   = 24'h0;
    tick(3);
    check("rst_write", 32'(AVL_WRITE), 32'd0);
    check("rst_addr", 32'(AVL_ADDR), 32'h0);
    check("rst_data", AVL_WRITEDATA, 32'h0);
    check("rst_sweep", 32'(SWEEP_ACTIVE), 32'd0);
    check("rst_drop", 32'(DROP_CNT), 32'h0);
    RESET = 1'b0;
    tick(1);
    check("rst_a_ready", 32'(A_READY), 32'd1);
    check("rst_b_ready", 32'(B_READY), 32'd1);

    // Note-on latency and decode.
    base    = wr_n;
    A_VALID = 1'b1;
    A_MSG   = 24'h903C64;
    pcyc    = cyc;
    tick(1);
    A_VALID = 1'b0;
    wait_writes(base + 1, 20);
    check("noteon_latency", wr_cyc[base] - pcyc, 32'd3);
    check("noteon_addr", 32'(wr_addr[base]), 32'h3C);
    check("noteon_data", wr_data[base], 32'h0000_00E4);
    tick(2);
    check("write_one_cycle", 32'(AVL_WRITE), 32'd0);
    check("addr_held", 32'(AVL_ADDR), 32'h3C);
    check("data_held", AVL_WRITEDATA, 32'h0000_00E4);
    check("single_write", wr_n, base + 1);

    // Note-off forms: zero-velocity note-on from A, then 0x80 from B.
    base = wr_n;
    push_a(24'h903C00);
    wait_writes(base + 1, 20);
    push_b(24'h803C10);
    wait_writes(base + 2, 20);
    check("noteoff0_addr", 32'(wr_addr[base]), 32'h3C);
    check("noteoff0_data", wr_data[base], 32'h0);
    check("noteoff1_addr", 32'(wr_addr[base+1]), 32'h3C);
    check("noteoff1_data", wr_data[base+1], 32'h10);

    // Both sources loaded together; last grant was B, so A goes first.
    tick(3);
    base    = wr_n;
    A_VALID = 1'b1;
    B_VALID = 1'b1;
    A_MSG   = 24'h900101;
    B_MSG   = 24'h901111;
    tick(1);
    A_MSG   = 24'h900202;
    B_MSG   = 24'h901212;
    tick(1);
    A_MSG   = 24'h900303;
    B_MSG   = 24'h901313;
    tick(1);
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    wait_writes(base + 6, 60);
    ord[0] = 8'h01; ord[1] = 8'h11; ord[2] = 8'h02;
    ord[3] = 8'h12; ord[4] = 8'h03; ord[5] = 8'h13;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_order_%0d", i), 32'(wr_addr[base+i]), 32'(ord[i]));
    end
    check("rr_data0", wr_data[base], 32'h81);

    // FIFO full while disabled: READY drops, extra message refused.
    tick(3);
    ENABLE = 1'b0;
    base   = wr_n;
    push_a(24'h902121);
    push_a(24'h902222);
    push_a(24'h902323);
    push_a(24'h902424);
    check("full_a_ready", 32'(A_READY), 32'd0);
    check("full_b_ready", 32'(B_READY), 32'd1);
    A_VALID = 1'b1;
    A_MSG   = 24'h902525;
    tick(1);
    A_VALID = 1'b0;
    tick(3);
    check("disabled_no_write", wr_n, base);
    check("full_a_ready_hold", 32'(A_READY), 32'd0);
    ENABLE = 1'b1;
    wait_writes(base + 4, 40);
    tick(10);
    check("full_write_count", wr_n, base + 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_addr_%0d", i), 32'(wr_addr[base+i]), 32'h21 + i);
    end
    check("drained_a_ready", 32'(A_READY), 32'd1);

    // ENABLE falling while in DECODE: current message still written.
    tick(2);
    base    = wr_n;
    A_VALID = 1'b1;
    A_MSG   = 24'h903030;
    tick(1);
    A_VALID = 1'b0;
    tick(1);
    ENABLE = 1'b0;
    wait_writes(base + 1, 10);
    check("en_fall_addr", 32'(wr_addr[base]), 32'h30);
    push_a(24'h903131);
    tick(6);
    check("en_low_blocks", wr_n, base + 1);
    ENABLE = 1'b1;
    wait_writes(base + 2, 10);
    check("en_resume_addr", 32'(wr_addr[base+1]), 32'h31);

    // Control changes: sustain and ctrl index 1.
    base = wr_n;
    push_a(24'hB04050);
    push_a(24'hB01101);
    wait_writes(base + 2, 20);
    check("cc64_addr", 32'(wr_addr[base]), 32'h86);
    check("cc64_data", wr_data[base], 32'h50);
    check("cc17_addr", 32'(wr_addr[base+1]), 32'h81);
    check("cc17_data", wr_data[base+1], 32'h0000_2000);

    // Drops and DROP_CNT saturation.
    tick(3);
    base = wr_n;
    check("drop_start", 32'(DROP_CNT), 32'h0);
    push_a(24'h913C40);
    push_b(24'hE00000);
    tick(8);
    check("drop_two", 32'(DROP_CNT), 32'h2);
    check("drop_no_write", wr_n, base);
    push_a(24'h908010);
    push_b(24'hB00700);
    tick(8);
    check("drop_four", 32'(DROP_CNT), 32'h4);
    for (int i = 0; i < 251; i++) push_a(24'hE00000);
    tick(20);
    check("drop_reach_ff", 32'(DROP_CNT), 32'hFF);
    for (int i = 0; i < 49; i++) push_a(24'hE00000);
    tick(20);
    check("drop_saturate", 32'(DROP_CNT), 32'hFF);
    check("drop_no_write2", wr_n, base);

    // Full sweep; ENABLE dropped mid-sweep has no effect.
    tick(3);
    base = wr_n;
    push_a(24'hB07B00);
    wait_writes(base + 10, 30);
    ENABLE = 1'b0;
    check("sweep_active_mid", 32'(SWEEP_ACTIVE), 32'd1);
    wait_writes(base + 128, 300);
    ENABLE = 1'b1;
    tick(5);
    check("sweep_count", wr_n, base + 128);
    for (int k = 0; k < 128; k++) begin
      check($sformatf("sweep_addr_%0d", k), 32'(wr_addr[base+k]), k);
      check($sformatf("sweep_data_%0d", k), wr_data[base+k], 32'h0);
      check($sformatf("sweep_flag_%0d", k), 32'(wr_sw[base+k]), 32'd1);
    end
    check("sweep_contiguous", wr_cyc[base+127] - wr_cyc[base], 32'd127);
    check("sweep_end_flag", 32'(SWEEP_ACTIVE), 32'd0);
    check("sweep_end_write", 32'(AVL_WRITE), 32'd0);

    // Reset during a sweep after 50 writes.
    base = wr_n;
    push_a(24'hB07B00);
    wait_writes(base + 50, 100);
    RESET = 1'b1;
    tick(1);
    check("abort_write", 32'(AVL_WRITE), 32'd0);
    check("abort_addr", 32'(AVL_ADDR), 32'h0);
    check("abort_data", AVL_WRITEDATA, 32'h0);
    check("abort_sweep", 32'(SWEEP_ACTIVE), 32'd0);
    check("abort_drop", 32'(DROP_CNT), 32'h0);
    tick(2);
    RESET = 1'b0;
    tick(10);
    check("abort_count", wr_n, base + 50);
    check("abort_a_ready", 32'(A_READY), 32'd1);
    check("abort_b_ready", 32'(B_READY), 32'd1);

    // After reset the last-grant flag is A, so B wins a tie.
    base    = wr_n;
    A_VALID = 1'b1;
    B_VALID = 1'b1;
    A_MSG   = 24'h904141;
    B_MSG   = 24'h904242;
    tick(1);
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    wait_writes(base + 2, 20);
    check("rst_grant_first", 32'(wr_addr[base]), 32'h42);
    check("rst_grant_second", 32'(wr_addr[base+1]), 32'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
